// File: rtl/jtframe_ram.sv
// Single-port byte RAM with a registered read port.
// Both the read and the write happen on the same edge. The read returns the
// contents from before that edge.
module jtframe_ram #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] q
);

  logic [DW-1:0] r_mem [0:(2**AW)-1];

  // Write when enabled, always register the addressed word.
  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= data;
    q <= r_mem[addr];
  end

endmodule

// File: rtl/jtkiwi_shr_pick.sv
// Combinational winner select for the shared RAM arbiter.
// Round-robin mode searches upward from i_ptr and wraps at NCPU-1.
// Fixed mode picks the lowest requesting index.
module jtkiwi_shr_pick #(
  parameter int NCPU = 2,
  parameter int CW   = 1
) (
  input  logic [NCPU-1:0] i_req,
  input  logic [CW-1:0]   i_ptr,
  input  logic            i_mode,
  output logic [CW-1:0]   o_g,
  output logic            o_valid
);

  // Scan the candidates from the lowest priority down to the highest, so the
  // last hit is the winner and no early exit is needed.
  always_comb begin
    int idx;
    o_g     = '0;
    o_valid = 1'b0;
    idx     = 0;
    if (i_mode) begin
      for (int i = NCPU - 1; i >= 0; i--) begin
        if (i_req[i]) begin
          o_g     = CW'(i);
          o_valid = 1'b1;
        end
      end
    end else begin
      for (int k = NCPU - 1; k >= 0; k--) begin
        idx = int'(i_ptr) + k;
        if (idx >= NCPU) idx = idx - NCPU;
        if (i_req[idx]) begin
          o_g     = CW'(idx);
          o_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/jtkiwi_shr_arb.sv
// N-port arbiter in front of one shared work RAM for the CPU wrappers.
// The pipeline issues one grant per cen cycle.
//   S0 registers the winner and its request.
//   S1 accesses the RAM.
//   S2 returns ok and the read data to the port.
// Handshake: a port raises cs and keeps it high, together with rnw, addr and
// din, until it sees ok. ok then stays high until cs drops. Each cs assertion
// produces exactly one access. A port that is gated off by en is invisible to
// the arbiter. If cs or en drops mid-access, the RAM side still completes, but
// ok and dout are left alone.
module jtkiwi_shr_arb #(
  parameter int NCPU = 2,
  parameter int AW   = 13,
  parameter int DW   = 8,
  parameter int PRIO = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cen,
  input  logic [NCPU-1:0]    cs,
  input  logic [NCPU-1:0]    en,
  input  logic [NCPU-1:0]    rnw,
  input  logic [NCPU*AW-1:0] addr,
  input  logic [NCPU*DW-1:0] din,
  output logic [NCPU*DW-1:0] dout,
  output logic [NCPU-1:0]    ok
);

  localparam int   CW       = $clog2(NCPU);
  localparam logic MODE_RR  = 1'b0;
  localparam logic MODE_FIX = 1'b1;
  localparam logic MODE_SEL = (PRIO != 0) ? MODE_FIX : MODE_RR;

  logic [CW-1:0]   r_ptr;
  logic [NCPU-1:0] r_served;

  logic            r_s1_vld;
  logic [CW-1:0]   r_s1_g;
  logic            r_s1_we;
  logic [AW-1:0]   r_s1_addr;
  logic [DW-1:0]   r_s1_din;

  logic            r_s2_vld;
  logic [CW-1:0]   r_s2_g;
  logic            r_s2_we;

  logic [NCPU-1:0] w_busy;
  logic [NCPU-1:0] w_req;
  logic [CW-1:0]   w_g;
  logic            w_valid;
  logic            w_grant;
  logic [CW-1:0]   w_ptr_nxt;
  logic [DW-1:0]   w_rd;

  // Ports with an access sitting in S1 or S2 cannot be granted again.
  always_comb begin
    w_busy = '0;
    if (r_s1_vld) w_busy[r_s1_g] = 1'b1;
    if (r_s2_vld) w_busy[r_s2_g] = 1'b1;
  end

  assign w_req     = cs & en & ~r_served & ~w_busy;
  assign w_grant   = cen & w_valid;
  assign w_ptr_nxt = (w_g == CW'(NCPU - 1)) ? '0 : w_g + CW'(1);

  jtkiwi_shr_pick #(
    .NCPU (NCPU),
    .CW   (CW)
  ) u_pick (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .i_mode  (MODE_SEL),
    .o_g     (w_g),
    .o_valid (w_valid)
  );

  // S0: capture the winner's request and advance the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_ptr     <= '0;
      r_s1_g    <= '0;
      r_s1_we   <= 1'b0;
      r_s1_addr <= '0;
      r_s1_din  <= '0;
    end else begin
      r_s1_vld <= w_grant;
      if (w_grant) begin
        r_s1_g    <= w_g;
        r_s1_we   <= ~rnw[w_g];
        r_s1_addr <= addr[w_g*AW +: AW];
        r_s1_din  <= din[w_g*DW +: DW];
        r_ptr     <= w_ptr_nxt;
      end
    end
  end

  jtframe_ram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clk  (clk),
    .we   (r_s1_vld & r_s1_we),
    .addr (r_s1_addr),
    .data (r_s1_din),
    .q    (w_rd)
  );

  // S1: the RAM is accessed on this edge. Carry the port identity along with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_vld <= 1'b0;
      r_s2_g   <= '0;
      r_s2_we  <= 1'b0;
    end else begin
      r_s2_vld <= r_s1_vld;
      r_s2_g   <= r_s1_g;
      r_s2_we  <= r_s1_we;
    end
  end

  // S2: return ok and read data to the port if it still wants them.
  // ok and served clear once cs drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      ok       <= '0;
      r_served <= '0;
      dout     <= '0;
    end else begin
      for (int i = 0; i < NCPU; i++) begin
        if (!cs[i]) begin
          ok[i]       <= 1'b0;
          r_served[i] <= 1'b0;
        end
        if (r_s2_vld && (r_s2_g == CW'(i)) && cs[i] && en[i]) begin
          ok[i]       <= 1'b1;
          r_served[i] <= 1'b1;
          if (!r_s2_we) dout[i*DW +: DW] <= w_rd;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtkiwi_shr_arb.sv
// Bench for jtkiwi_shr_arb.
//   u_rr: NCPU=3, round-robin. Tracked every cycle against a transaction-queue model.
//   u_fx: NCPU=2, fixed priority. Checked with hand-computed literals.
module tb_jtkiwi_shr_arb;

  localparam int N  = 3;
  localparam int AW = 13;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             cen;
  logic [N-1:0]     cs, en, rnw;
  logic [N*AW-1:0]  addr;
  logic [N*DW-1:0]  din;
  logic [N*DW-1:0]  dout;
  logic [N-1:0]     ok;

  logic [1:0]       fx_cs, fx_en, fx_rnw;
  logic [2*AW-1:0]  fx_addr;
  logic [2*DW-1:0]  fx_din;
  logic [2*DW-1:0]  fx_dout;
  logic [1:0]       fx_ok;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  jtkiwi_shr_arb #(.NCPU(N), .AW(AW), .DW(DW), .PRIO(0)) u_rr (
    .clk(clk), .rst(rst), .cen(cen), .cs(cs), .en(en), .rnw(rnw),
    .addr(addr), .din(din), .dout(dout), .ok(ok)
  );

  jtkiwi_shr_arb #(.NCPU(2), .AW(AW), .DW(DW), .PRIO(1)) u_fx (
    .clk(clk), .rst(rst), .cen(cen), .cs(fx_cs), .en(fx_en), .rnw(fx_rnw),
    .addr(fx_addr), .din(fx_din), .dout(fx_dout), .ok(fx_ok)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model of u_rr ----------------
  typedef struct {
    int         port;
    bit         we;
    int         a;
    logic [7:0] d;
    logic [7:0] rd;
    bit         rk;
    int         gc;
  } txn_t;

  txn_t       m_q[$];
  logic [7:0] m_mem[int];
  bit         m_ok[N];
  logic [7:0] m_dout[N];
  bit         m_dk[N];
  bit         m_served[N];
  int         m_ptr   = 0;
  bit         m_valid = 0;
  int         mn      = 0;

  always @(posedge clk) begin : model
    bit busy[N];
    bit nsrv[N];
    int g;
    bit found;
    mn = mn + 1;
    if (rst) begin
      foreach (m_q[j]) if (m_q[j].we) m_mem.delete(m_q[j].a);
      m_q.delete();
      for (int i = 0; i < N; i++) begin
        m_ok[i] = 0; m_dout[i] = 8'h00; m_dk[i] = 1; m_served[i] = 0;
      end
      m_ptr   = 0;
      m_valid = 1;
    end else if (m_valid) begin
      for (int i = 0; i < N; i++) busy[i] = 0;
      foreach (m_q[j]) busy[m_q[j].port] = 1;
      // A transaction granted on the previous edge touches memory now.
      foreach (m_q[j]) begin
        if (m_q[j].gc == mn - 1) begin
          if (m_q[j].we) m_mem[m_q[j].a] = m_q[j].d;
          else begin
            m_q[j].rk = m_mem.exists(m_q[j].a);
            m_q[j].rd = m_q[j].rk ? m_mem[m_q[j].a] : 8'h00;
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        nsrv[i] = m_served[i];
        if (!cs[i]) begin m_ok[i] = 0; nsrv[i] = 0; end
      end
      // A transaction granted two edges ago reports back now.
      if (m_q.size() > 0 && m_q[0].gc == mn - 2) begin
        int p;
        p = m_q[0].port;
        if (cs[p] && en[p]) begin
          m_ok[p] = 1;
          nsrv[p] = 1;
          if (!m_q[0].we) begin m_dout[p] = m_q[0].rd; m_dk[p] = m_q[0].rk; end
        end
        void'(m_q.pop_front());
      end
      found = 0;
      g     = 0;
      if (cen) begin
        for (int k = 0; k < N && !found; k++) begin
          int p2;
          p2 = (m_ptr + k) % N;
          if (cs[p2] && en[p2] && !m_served[p2] && !busy[p2]) begin
            found = 1; g = p2;
          end
        end
      end
      if (found) begin
        m_q.push_back('{g, !rnw[g], int'(addr[g*AW +: AW]), din[g*DW +: DW], 8'h00, 1'b0, mn});
        m_ptr = (g + 1) % N;
      end
      for (int i = 0; i < N; i++) m_served[i] = nsrv[i];
    end
  end

  // Compare u_rr against the model on every cycle after the first reset.
  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (ok[i] !== m_ok[i]) begin
          errors++;
          $display("FAIL model_ok[%0d] cyc %0d: got %b expected %b", i, cyc, ok[i], m_ok[i]);
        end
        if (m_dk[i]) begin
          checks++;
          if (dout[i*DW +: DW] !== m_dout[i]) begin
            errors++;
            $display("FAIL model_dout[%0d] cyc %0d: got %0h expected %0h", i, cyc, dout[i*DW +: DW], m_dout[i]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_port(input int p, input bit c, input bit r, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cs[p]             = c;
    rnw[p]            = r;
    addr[p*AW +: AW]  = a;
    din[p*DW +: DW]   = d;
  endtask

  task automatic fx_set(input int p, input bit c, input bit r, input logic [AW-1:0] a, input logic [DW-1:0] d);
    fx_cs[p]            = c;
    fx_rnw[p]           = r;
    fx_addr[p*AW +: AW] = a;
    fx_din[p*DW +: DW]  = d;
  endtask

  task automatic release_all();
    cs    = '0;
    fx_cs = '0;
    @(negedge clk);
  endtask

  task automatic wait_ok(input int p, input int lim, output int at);
    at = -1;
    for (int c = 0; c < lim; c++) begin
      @(negedge clk);
      if (ok[p]) begin at = cyc; return; end
    end
  endtask

  task automatic watch_rr(input int lim, output int t0, output int t1, output int t2);
    t0 = -1; t1 = -1; t2 = -1;
    for (int c = 0; c < lim; c++) begin
      @(negedge clk);
      if (ok[0] && t0 < 0) t0 = cyc;
      if (ok[1] && t1 < 0) t1 = cyc;
      if (ok[2] && t2 < 0) t2 = cyc;
    end
  endtask

  task automatic watch_fx(input int lim, output int t0, output int t1);
    t0 = -1; t1 = -1;
    for (int c = 0; c < lim; c++) begin
      @(negedge clk);
      if (fx_ok[0] && t0 < 0) t0 = cyc;
      if (fx_ok[1] && t1 < 0) t1 = cyc;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int k, at, t0, t1, t2;
    rst = 1; cen = 1;
    cs = '0; en = '1; rnw = '1; addr = '0; din = '0;
    fx_cs = '0; fx_en = 2'b11; fx_rnw = 2'b11; fx_addr = '0; fx_din = '0;
    repeat (3) @(negedge clk);
    chk("reset_ok", int'(ok), 0);
    chk("reset_dout", int'(dout), 0);
    rst = 0;
    @(negedge clk);

    // Port 0 writes 0x5A to 0x0123, then reads it back.
    set_port(0, 1, 0, 13'h0123, 8'h5A); k = cyc;
    wait_ok(0, 10, at);
    chk("t1_write_latency", at, k + 3);
    chk("t1_write_dout_unchanged", int'(dout[7:0]), 0);
    release_all();
    set_port(0, 1, 1, 13'h0123, 8'h00); k = cyc;
    wait_ok(0, 10, at);
    chk("t1_read_latency", at, k + 3);
    chk("t1_read_data", int'(dout[7:0]), 8'h5A);
    release_all();

    // A port 2 write moves the pointer back to 0, then all three ports write.
    set_port(2, 1, 0, 13'h0200, 8'h77);
    wait_ok(2, 10, at);
    release_all();
    set_port(0, 1, 0, 13'h0010, 8'h11);
    set_port(1, 1, 0, 13'h0011, 8'h22);
    set_port(2, 1, 0, 13'h0012, 8'h33); k = cyc;
    watch_rr(8, t0, t1, t2);
    chk("t2_ok0_time", t0, k + 3);
    chk("t2_ok1_time", t1, k + 4);
    chk("t2_ok2_time", t2, k + 5);
    release_all();
    set_port(0, 1, 1, 13'h0010, 8'h00);
    set_port(1, 1, 1, 13'h0011, 8'h00);
    set_port(2, 1, 1, 13'h0012, 8'h00);
    watch_rr(8, t0, t1, t2);
    chk("t2_rd0", int'(dout[7:0]), 8'h11);
    chk("t2_rd1", int'(dout[15:8]), 8'h22);
    chk("t2_rd2", int'(dout[23:16]), 8'h33);
    release_all();

    // Port 1 writes 0x1FFF, and port 0 reads it on the next grant.
    set_port(1, 1, 0, 13'h1FFF, 8'hA5); k = cyc;
    @(negedge clk);
    set_port(0, 1, 1, 13'h1FFF, 8'h00);
    watch_rr(6, t0, t1, t2);
    chk("t4_ok1_time", t1, k + 3);
    chk("t4_ok0_time", t0, k + 4);
    chk("t4_rd_after_wr", int'(dout[7:0]), 8'hA5);
    release_all();

    // Port 1 is gated off by en while port 0 works.
    en[1] = 0;
    set_port(1, 1, 1, 13'h0123, 8'h00);
    set_port(0, 1, 0, 13'h0300, 8'h66);
    wait_ok(0, 10, at);
    chk("t5_port0_served", at >= 0 ? 1 : 0, 1);
    chk("t5_ok1_gated", int'(ok[1]), 0);
    cs[0] = 0;
    repeat (4) @(negedge clk);
    chk("t5_ok1_still_gated", int'(ok[1]), 0);
    en[1] = 1; k = cyc;
    wait_ok(1, 10, at);
    chk("t5_ok1_after_en", at, k + 3);
    chk("t5_rd1", int'(dout[15:8]), 8'h5A);
    release_all();

    // With cen low, no grant is made.
    cen = 0;
    set_port(2, 1, 1, 13'h0200, 8'h00);
    repeat (5) @(negedge clk);
    chk("cen_hold_ok2", int'(ok[2]), 0);
    cen = 1; k = cyc;
    wait_ok(2, 10, at);
    chk("cen_resume_time", at, k + 3);
    chk("cen_resume_data", int'(dout[23:16]), 8'h77);
    release_all();

    // cs drops after the grant. The write lands, but ok never rises.
    set_port(2, 1, 0, 13'h0400, 8'h99);
    @(negedge clk);
    cs[2] = 0;
    repeat (4) @(negedge clk);
    chk("drop_cs_no_ok", int'(ok[2]), 0);
    set_port(0, 1, 1, 13'h0400, 8'h00);
    wait_ok(0, 10, at);
    chk("drop_cs_write_landed", int'(dout[7:0]), 8'h99);
    release_all();

    // Reset during S1 of a read. The pointer is 1 here, and reset returns it to 0.
    set_port(0, 1, 1, 13'h0123, 8'h00);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("t6_ok_flushed", int'(ok), 0);
    chk("t6_dout_cleared", int'(dout), 0);
    rst = 0;
    release_all();
    set_port(0, 1, 1, 13'h0123, 8'h00);
    set_port(1, 1, 1, 13'h0123, 8'h00); k = cyc;
    watch_rr(6, t0, t1, t2);
    chk("t6_ptr0_first", t0, k + 3);
    chk("t6_port1_second", t1, k + 4);
    chk("t6_rd0", int'(dout[7:0]), 8'h5A);
    chk("t6_rd1", int'(dout[15:8]), 8'h5A);
    release_all();

    // Fixed priority: port 0 alone first, then both ports together.
    fx_set(0, 1, 0, 13'h0040, 8'h3C); k = cyc;
    watch_fx(5, t0, t1);
    chk("fx_alone_time", t0, k + 3);
    chk("fx_write_dout_unchanged", int'(fx_dout[7:0]), 0);
    release_all();
    fx_set(0, 1, 0, 13'h0050, 8'h4B);
    fx_set(1, 1, 1, 13'h0050, 8'h00); k = cyc;
    watch_fx(6, t0, t1);
    chk("fx_port0_first", t0, k + 3);
    chk("fx_port1_next", t1, k + 4);
    chk("fx_rd1_sees_write", int'(fx_dout[15:8]), 8'h4B);
    release_all();
    fx_set(1, 1, 1, 13'h0040, 8'h00);
    fx_set(0, 1, 1, 13'h0050, 8'h00); k = cyc;
    watch_fx(6, t0, t1);
    chk("fx_again_port0_first", t0, k + 3);
    chk("fx_again_port1", t1, k + 4);
    chk("fx_rd0", int'(fx_dout[7:0]), 8'h4B);
    chk("fx_rd1", int'(fx_dout[15:8]), 8'h3C);
    release_all();

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
